md_ram_rd: RTL

Read-side sequencer for the pre-intra mode-decision 8x8 result RAM (16 words x 32 bit, two-port register file, 1-cycle read latency). On a start pulse it sweeps all 2^ADDR_WIDTH words of one 32x32 CU's 8x8 results, drives the RAM read port, and delivers the words to the downstream mode-decision consumer over a valid/ready stream. A 2-entry output buffer absorbs the RAM read latency under backpressure. Full throughput is one word per cycle.

---
 rtl/md_ram_rd.sv | 129 ++++++++++++
 1 files changed

// File: rtl/md_ram_rd.sv
// md_ram_rd: read-side sequencer for the mode-decision 8x8 result RAM of one 32x32 CU.
// Define MD_RAM_RD_ZSCAN_EN to sweep the RAM in Z-scan order instead of raster order.
module md_ram_rd #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  rd_o,
   output logic [ADDR_WIDTH-1:0] raddr_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  val_o,
   output logic [DATA_WIDTH-1:0] dat_o,
   output logic [ADDR_WIDTH-1:0] idx_o,
   input  logic                  rdy_i
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] LAST = CW'(2**ADDR_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                state;
   logic [CW-1:0]         c;
   logic [CW-1:0]         a;
   logic                  vld_p1;
   logic [ADDR_WIDTH-1:0] idx_p1;
   logic [DATA_WIDTH-1:0] buf_dat [2];
   logic [ADDR_WIDTH-1:0] buf_idx [2];
   logic                  wptr;
   logic                  rptr;
   logic [1:0]            occ;
   logic                  pop;
   logic [2:0]            pend;

   function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] cnt);
`ifdef MD_RAM_RD_ZSCAN_EN
      return {cnt[3], cnt[1], cnt[2], cnt[0]};
`else
      return cnt;
`endif
   endfunction

   assign pop     = val_o && rdy_i;
   // Words already owed to the buffer after this cycle's pop; never let it exceed 2.
   assign pend    = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
   assign rd_o    = (state == READ) && (pend < 3'd2);
   assign raddr_o = map_addr(c[ADDR_WIDTH-1:0]);
   assign val_o   = (occ != 2'd0);
   assign dat_o   = buf_dat[rptr];
   assign idx_o   = buf_idx[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         c      <= '0;
         a      <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  state  <= READ;
                  c      <= '0;
                  a      <= '0;
                  busy_o <= 1'b1;
               end
            end
            READ: begin
               if (rd_o) begin
                  c <= c + 1'b1;
                  if (c == LAST) state <= DRAIN;
               end
               if (pop) a <= a + 1'b1;
            end
            DRAIN: begin
               if (pop) begin
                  a <= a + 1'b1;
                  if (a == LAST) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // p1: read issued, RAM data returns next cycle
   always_ff @(posedge clk) begin
      if (rd_o) idx_p1 <= c[ADDR_WIDTH-1:0];
   end

   // p2: capture returning word into the 2-entry output buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         wptr    <= 1'b0;
         rptr    <= 1'b0;
         occ     <= 2'd0;
         buf_dat <= '{default: '0};
         buf_idx <= '{default: '0};
      end else begin
         vld_p1 <= rd_o;
         if (vld_p1) begin
            buf_dat[wptr] <= rdata_i;
            buf_idx[wptr] <= idx_p1;
            wptr          <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
      end
   end

`ifndef SYNTHESIS
   a_occ: assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
`endif

endmodule
